// File: rtl/cpu_dma_rx_queue_pkg.sv
// Shared control encodings and types for the CPU RX queue and the DMA queue interface.
package cpu_dma_rx_queue_pkg;

    localparam logic [7:0] CPU_Q_CTRL_HDR  = 8'hFF;
    localparam logic [7:0] CPU_Q_CTRL_DATA = 8'h00;

    typedef enum logic {
        StHdr,
        StData
    } wr_state_e;

    // True when the end-of-packet byte lies in the upper 32-bit half of a 64-bit word.
    function automatic logic upper_eop(input logic [7:0] ctrl);
        return ctrl[7:4] != 4'h0;
    endfunction

endpackage

// File: rtl/cpu_dma_rx_queue_fifo.sv
// First-word-fall-through FIFO with full/empty and a registered nearly-full flag.
module cpu_dma_rx_queue_fifo #(
    parameter int unsigned WIDTH  = 72,
    parameter int unsigned ADDR_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             nearly_full
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] NF_LEVEL   = (ADDR_W + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              nearly_full_q;

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Held set through reset so upstream sees not-ready until the queue is live.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            nearly_full_q <= 1'b1;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q       <= count_d;
            nearly_full_q <= count_d >= NF_LEVEL;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= din;
    end

    assign dout        = mem[rd_ptr_q];
    assign full        = count_q == FULL_LEVEL;
    assign empty       = count_q == '0;
    assign nearly_full = nearly_full_q;

endmodule

// File: rtl/cpu_dma_rx_queue.sv
// CPU RX queue: strips module headers, buffers whole packets and serves them as 32-bit DMA words.
module cpu_dma_rx_queue
    import cpu_dma_rx_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned DMA_DATA_WIDTH = DATA_WIDTH / 2,
    parameter int unsigned ADDR_W         = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic [DATA_WIDTH/8-1:0]     in_ctrl,
    input  logic                        in_wr,
    output logic                        in_rdy,
    output logic                        cpu_q_dma_pkt_avail,
    input  logic                        cpu_q_dma_rd,
    output logic [DMA_DATA_WIDTH-1:0]   cpu_q_dma_rd_data,
    output logic [DMA_DATA_WIDTH/8-1:0] cpu_q_dma_rd_ctrl,
    output logic                        pkt_stored,
    output logic                        pkt_removed,
    output logic                        overflow_err
);

    localparam int unsigned CW  = DATA_WIDTH / 8;
    localparam int unsigned DCW = DMA_DATA_WIDTH / 8;
    localparam int unsigned EW  = DATA_WIDTH + CW;

    logic [EW-1:0]   head;
    logic            full, empty, nearly_full;
    wr_state_e       state_q, state_d;
    logic            half_hi_q, half_hi_d;
    logic [ADDR_W:0] pkt_cnt_q, pkt_cnt_d;
    logic            pkt_avail_q, pkt_stored_q, pkt_removed_q, overflow_q;
    logic            store, store_last, rd_ok, pop, eop_rd;
    logic [CW-1:0]   head_ctrl;

    cpu_dma_rx_queue_fifo #(
        .WIDTH  (EW),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (store),
        .rd_en       (pop),
        .dout        (head),
        .full        (full),
        .empty       (empty),
        .nearly_full (nearly_full)
    );

    // Write side: words arriving while full are dropped without moving the FSM.
    always_comb begin
        store      = 1'b0;
        store_last = 1'b0;
        state_d    = state_q;
        if (in_wr && !full) begin
            unique case (state_q)
                StHdr: begin
                    if (in_ctrl == CPU_Q_CTRL_DATA) begin
                        store   = 1'b1;
                        state_d = StData;
                    end else if (in_ctrl != CPU_Q_CTRL_HDR) begin
                        store      = 1'b1;
                        store_last = 1'b1;
                    end
                end
                StData: begin
                    store = 1'b1;
                    if (in_ctrl != CPU_Q_CTRL_DATA) begin
                        store_last = 1'b1;
                        state_d    = StHdr;
                    end
                end
                default: state_d = StHdr;
            endcase
        end
    end

    assign head_ctrl         = head[EW-1 -: CW];
    assign cpu_q_dma_rd_data = half_hi_q ? head[DATA_WIDTH-1 -: DMA_DATA_WIDTH]
                                         : head[DMA_DATA_WIDTH-1:0];
    assign cpu_q_dma_rd_ctrl = half_hi_q ? head_ctrl[CW-1 -: DCW] : head_ctrl[DCW-1:0];

    // An EOP in the upper half pops the entry directly; the lower half is never presented.
    always_comb begin
        rd_ok     = cpu_q_dma_rd && (pkt_cnt_q != '0) && !empty;
        pop       = rd_ok && (!half_hi_q || upper_eop(head_ctrl));
        eop_rd    = rd_ok && (cpu_q_dma_rd_ctrl != '0);
        half_hi_d = rd_ok ? pop : half_hi_q;
        pkt_cnt_d = pkt_cnt_q;
        if (store_last && !eop_rd) pkt_cnt_d = pkt_cnt_q + 1'b1;
        else if (!store_last && eop_rd) pkt_cnt_d = pkt_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StHdr;
            half_hi_q     <= 1'b1;
            pkt_cnt_q     <= '0;
            pkt_avail_q   <= 1'b0;
            pkt_stored_q  <= 1'b0;
            pkt_removed_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            half_hi_q     <= half_hi_d;
            pkt_cnt_q     <= pkt_cnt_d;
            pkt_avail_q   <= pkt_cnt_q != '0;
            pkt_stored_q  <= store_last;
            pkt_removed_q <= eop_rd;
            overflow_q    <= in_wr && full;
        end
    end

    assign in_rdy              = !nearly_full;
    assign cpu_q_dma_pkt_avail = pkt_avail_q;
    assign pkt_stored          = pkt_stored_q;
    assign pkt_removed         = pkt_removed_q;
    assign overflow_err        = overflow_q;

endmodule

// File: tb/tb_cpu_dma_rx_queue.sv
// Directed bench for cpu_dma_rx_queue with a scoreboard of expected 32-bit DMA words.
module tb_cpu_dma_rx_queue;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic        cpu_q_dma_pkt_avail;
    logic        cpu_q_dma_rd;
    logic [31:0] cpu_q_dma_rd_data;
    logic [3:0]  cpu_q_dma_rd_ctrl;
    logic        pkt_stored;
    logic        pkt_removed;
    logic        overflow_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [35:0] sb[$];

    cpu_dma_rx_queue #(
        .DATA_WIDTH     (64),
        .DMA_DATA_WIDTH (32),
        .ADDR_W         (ADDR_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_data             (in_data),
        .in_ctrl             (in_ctrl),
        .in_wr               (in_wr),
        .in_rdy              (in_rdy),
        .cpu_q_dma_pkt_avail (cpu_q_dma_pkt_avail),
        .cpu_q_dma_rd        (cpu_q_dma_rd),
        .cpu_q_dma_rd_data   (cpu_q_dma_rd_data),
        .cpu_q_dma_rd_ctrl   (cpu_q_dma_rd_ctrl),
        .pkt_stored          (pkt_stored),
        .pkt_removed         (pkt_removed),
        .overflow_err        (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected DMA words for one stored 64-bit word.
    function automatic void push_words(input logic [63:0] d, input logic [7:0] c);
        if (c == 8'h00) begin
            sb.push_back({d[63:32], 4'h0});
            sb.push_back({d[31:0], 4'h0});
        end else if (c[7:4] != 4'h0) begin
            sb.push_back({d[63:32], c[7:4]});
        end else begin
            sb.push_back({d[63:32], 4'h0});
            sb.push_back({d[31:0], c[3:0]});
        end
    endfunction

    task automatic wr_raw(input logic [63:0] d, input logic [7:0] c);
        in_data = d;
        in_ctrl = c;
        in_wr   = 1'b1;
        tick();
        in_wr   = 1'b0;
    endtask

    task automatic send_hdr();
        wr_raw(64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        check("hdr_no_store", pkt_stored, 1'b0);
    endtask

    task automatic send_data(input logic [63:0] d, input logic [7:0] c);
        push_words(d, c);
        wr_raw(d, c);
        check("pkt_stored", pkt_stored, c != 8'h00);
    endtask

    task automatic read_word();
        logic [35:0] e;
        check("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("rd_data", cpu_q_dma_rd_data, e[35:4]);
        check("rd_ctrl", cpu_q_dma_rd_ctrl, e[3:0]);
        cpu_q_dma_rd = 1'b1;
        tick();
        cpu_q_dma_rd = 1'b0;
        check("pkt_removed", pkt_removed, e[3:0] != 4'h0);
    endtask

    task automatic wait_avail();
        int n = 0;
        while (!cpu_q_dma_pkt_avail && n < 20) begin
            tick();
            n++;
        end
        check("pkt_avail_wait", cpu_q_dma_pkt_avail, 1'b1);
    endtask

    initial begin
        logic [35:0] e;
        logic [63:0] d;
        logic [7:0]  c;
        reset        = 1'b1;
        in_data      = '0;
        in_ctrl      = '0;
        in_wr        = 1'b0;
        cpu_q_dma_rd = 1'b0;
        repeat (3) tick();
        check("rst_in_rdy", in_rdy, 1'b0);
        check("rst_avail", cpu_q_dma_pkt_avail, 1'b0);
        check("rst_stored", pkt_stored, 1'b0);
        check("rst_removed", pkt_removed, 1'b0);
        check("rst_overflow", overflow_err, 1'b0);
        reset = 1'b0;
        tick();
        check("post_rst_in_rdy", in_rdy, 1'b1);

        // Header + two data words + last with EOP in the lower half.
        send_hdr();
        send_data(64'h1111_0001_1111_0002, 8'h00);
        send_data(64'h2222_0003_2222_0004, 8'h00);
        send_data(64'h3333_0005_3333_0006, 8'h08);
        check("avail_latency", cpu_q_dma_pkt_avail, 1'b0);
        wait_avail();
        repeat (6) read_word();
        tick();
        check("avail_drained1", cpu_q_dma_pkt_avail, 1'b0);

        // EOP in the upper half: lower half never presented.
        send_hdr();
        send_data(64'hAAAA_0001_BBBB_0002, 8'h00);
        send_data(64'hCCCC_0003_DDDD_0004, 8'h20);
        wait_avail();
        repeat (3) read_word();
        tick();
        check("avail_drained2", cpu_q_dma_pkt_avail, 1'b0);

        // Three back-to-back single-word packets.
        send_data(64'h0101_0101_0202_0202, 8'h01);
        send_data(64'h0303_0303_0404_0404, 8'h02);
        send_data(64'h0505_0505_0606_0606, 8'h80);
        wait_avail();
        repeat (5) read_word();
        tick();
        check("avail_drained3", cpu_q_dma_pkt_avail, 1'b0);

        // Fill with rd held low; in_rdy falls with one slot left, the next write overflows.
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_in_rdy", in_rdy, i < DEPTH - 1);
            d = {32'(i) ^ 32'h5A5A_0000, 32'(i) ^ 32'h0000_A5A5};
            c = 8'(1 << (i % 8));
            send_data(d, c);
            check("fill_no_overflow", overflow_err, 1'b0);
        end
        check("full_in_rdy", in_rdy, 1'b0);
        wr_raw(64'hFFFF_EEEE_DDDD_CCCC, 8'h01);
        check("overflow_pulse", overflow_err, 1'b1);
        check("overflow_no_store", pkt_stored, 1'b0);
        tick();
        check("overflow_clear", overflow_err, 1'b0);
        wait_avail();
        while (sb.size() != 0) read_word();
        tick();
        check("avail_drained4", cpu_q_dma_pkt_avail, 1'b0);
        check("in_rdy_after_drain", in_rdy, 1'b1);

        // Read attempt against a partial packet is ignored.
        send_hdr();
        send_data(64'h7777_1234_8888_5678, 8'h00);
        tick();
        check("partial_avail", cpu_q_dma_pkt_avail, 1'b0);
        e = sb[0];
        cpu_q_dma_rd = 1'b1;
        tick();
        cpu_q_dma_rd = 1'b0;
        check("partial_head_data", cpu_q_dma_rd_data, e[35:4]);
        check("partial_head_ctrl", cpu_q_dma_rd_ctrl, e[3:0]);
        check("partial_no_removed", pkt_removed, 1'b0);
        send_data(64'h9999_0001_9999_0002, 8'h01);
        wait_avail();
        repeat (3) read_word();

        // Last read of one packet coincides with last write of the next.
        e = sb.pop_front();
        check("coinc_rd_data", cpu_q_dma_rd_data, e[35:4]);
        check("coinc_rd_ctrl", cpu_q_dma_rd_ctrl, e[3:0]);
        push_words(64'h4444_ABCD_5555_EF01, 8'h04);
        in_data      = 64'h4444_ABCD_5555_EF01;
        in_ctrl      = 8'h04;
        in_wr        = 1'b1;
        cpu_q_dma_rd = 1'b1;
        tick();
        in_wr        = 1'b0;
        cpu_q_dma_rd = 1'b0;
        check("coinc_removed", pkt_removed, 1'b1);
        check("coinc_stored", pkt_stored, 1'b1);
        tick();
        check("coinc_avail", cpu_q_dma_pkt_avail, 1'b1);
        repeat (2) read_word();
        tick();
        check("avail_drained5", cpu_q_dma_pkt_avail, 1'b0);

        // Reset mid-packet discards the partial packet.
        send_hdr();
        wr_raw(64'h0BAD_0BAD_0BAD_0BAD, 8'h00);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("mid_rst_avail", cpu_q_dma_pkt_avail, 1'b0);
        check("mid_rst_in_rdy", in_rdy, 1'b1);
        send_hdr();
        send_data(64'h1357_9BDF_2468_ACE0, 8'h00);
        send_data(64'hFEDC_BA98_7654_3210, 8'h80);
        wait_avail();
        repeat (3) read_word();
        tick();
        check("avail_drained6", cpu_q_dma_pkt_avail, 1'b0);
        check("sb_empty_end", sb.size() == 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
